// File: rtl/lutram_test_pkg.sv
// Shared definitions for the LUTRAM primitive tests: pattern codes, checker
// state encoding and the expected-data function used by writer and checker.
package lutram_test_pkg;

  localparam int PAT_ADDR0  = 0;
  localparam int PAT_NADDR0 = 1;
  localparam int PAT_ZERO   = 2;
  localparam int PAT_ONE    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } chk_state_e;

  // Only the address LSB matters for every defined pattern.
  function automatic logic expected_bit(input int pat, input logic addr_lsb);
    case (pat)
      PAT_ADDR0:  return addr_lsb;
      PAT_NADDR0: return ~addr_lsb;
      PAT_ZERO:   return 1'b0;
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lutram_err_counter.sv
// Saturating error counter with synchronous clear; holds at all-ones.
module lutram_err_counter
  import lutram_test_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      count <= '0;
    else if (clr)                     count <= '0;
    else if (inc && (count != '1))    count <= count + 1'b1;
  end

endmodule

// File: rtl/lutram_read_checker.sv
// Read-phase checker for a distributed-RAM DUT: compares each sample against
// the written pattern and reduces the pass to flags, a count and first address.
module lutram_read_checker
  import lutram_test_pkg::*;
#(
  parameter int A_WIDTH   = 5,
  parameter int ERR_WIDTH = 8,
  parameter int PATTERN   = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 valid_i,
  input  logic [A_WIDTH-1:0]   addr_i,
  input  logic                 data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [ERR_WIDTH-1:0] err_count_o,
  output logic                 seq_err_o,
  output logic                 first_err_valid_o,
  output logic [A_WIDTH-1:0]   first_err_addr_o
);

  localparam logic [A_WIDTH-1:0] LAST_ADDR = '1;

  chk_state_e         state, state_next;
  logic [A_WIDTH-1:0] exp_addr;
  logic               arm, finish, accept, mismatch, out_of_order;

  assign accept       = (state == ST_CHECK) && valid_i;
  assign mismatch     = data_i != expected_bit(PATTERN, addr_i[0]);
  assign out_of_order = addr_i != exp_addr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    arm        = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE:  if (start_i) arm = 1'b1;
      ST_CHECK: if (valid_i && (exp_addr == LAST_ADDR)) finish = 1'b1;
      ST_DONE:  if (start_i) arm = 1'b1;
      default:  state_next = ST_IDLE;
    endcase
    if (arm)    state_next = ST_CHECK;
    if (finish) state_next = ST_DONE;
  end

  lutram_err_counter #(.W(ERR_WIDTH)) u_err_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr    (arm),
    .inc    (accept && mismatch),
    .count  (err_count_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_addr          <= '0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      pass_o            <= 1'b0;
      seq_err_o         <= 1'b0;
      first_err_valid_o <= 1'b0;
      first_err_addr_o  <= '0;
    end else begin
      busy_o <= (state_next == ST_CHECK);
      if (arm) begin
        exp_addr          <= '0;
        done_o            <= 1'b0;
        pass_o            <= 1'b0;
        seq_err_o         <= 1'b0;
        first_err_valid_o <= 1'b0;
        first_err_addr_o  <= '0;
      end else if (accept) begin
        exp_addr <= exp_addr + 1'b1;
        if (out_of_order) seq_err_o <= 1'b1;
        if (mismatch && !first_err_valid_o) begin
          first_err_valid_o <= 1'b1;
          first_err_addr_o  <= addr_i;
        end
        // The final sample's own verdict is folded in, since the flops lag it.
        if (finish) begin
          done_o <= 1'b1;
          pass_o <= (err_count_o == '0) && !mismatch && !seq_err_o && !out_of_order;
        end
      end
    end
  end

endmodule

// File: tb/tb_lutram_read_checker.sv
// Directed, table-driven bench for lutram_read_checker.
module tb_lutram_read_checker;
  import lutram_test_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, start, valid, data, data_b;
  logic [4:0] addr;

  logic       busy, done, pass, seq, fv;
  logic [7:0] cnt;
  logic [4:0] fa;
  logic       busy_b, done_b, pass_b, seq_b, fv_b;
  logic [1:0] cnt_b;
  logic [4:0] fa_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lutram_read_checker #(.A_WIDTH(5), .ERR_WIDTH(8), .PATTERN(PAT_ADDR0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .valid_i(valid),
    .addr_i(addr), .data_i(data), .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_count_o(cnt), .seq_err_o(seq), .first_err_valid_o(fv), .first_err_addr_o(fa)
  );

  // Constant-1 pattern, 2-bit counter, fed all zeros: every sample is wrong.
  lutram_read_checker #(.A_WIDTH(5), .ERR_WIDTH(2), .PATTERN(PAT_ONE)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .valid_i(valid),
    .addr_i(addr), .data_i(data_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
    .err_count_o(cnt_b), .seq_err_o(seq_b), .first_err_valid_o(fv_b), .first_err_addr_o(fa_b)
  );

  typedef struct {
    logic [31:0] mask;
    bit          dup;
    int          start_at;
    int          e_cnt;
    bit          e_fv;
    int          e_fa;
    bit          e_pass;
    bit          e_seq;
  } row_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " pass"}, pass, 0);
    chk({tag, " count"}, cnt, 0);
    chk({tag, " seq"}, seq, 0);
    chk({tag, " fv"}, fv, 0);
    chk({tag, " fa"}, fa, 0);
  endtask

  // Runs one full pass of 32 samples, issuing start from IDLE or DONE.
  task automatic run_pass(input string tag, input logic [31:0] mask, input bit dup,
                          input int start_at);
    logic [4:0] a;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy after start"}, busy, 1);
    chk({tag, " cleared done"}, done, 0);
    chk({tag, " cleared count"}, cnt, 0);
    chk({tag, " cleared fv"}, fv, 0);
    chk({tag, " cleared seq"}, seq, 0);
    for (int i = 0; i < 32; i++) begin
      a = (dup && i == 6) ? 5'd5 : 5'(i);
      valid = 1'b1;
      addr  = a;
      data  = a[0] ^ mask[a];
      start = (i == start_at);
      if (i == 31) chk({tag, " done before last"}, done, 0);
      @(negedge clk);
    end
    valid = 1'b0;
    start = 1'b0;
  endtask

  row_t rows[7];

  initial begin
    rows[0] = '{32'h0, 0, -1, 0, 0, 0, 1, 0};
    rows[1] = '{32'h1 << 13, 0, -1, 1, 1, 13, 0, 0};
    rows[2] = '{(32'h1 << 4) | (32'h1 << 9) | (32'h1 << 30), 0, -1, 3, 1, 4, 0, 0};
    rows[3] = '{32'h0, 1, -1, 0, 0, 0, 0, 1};
    rows[4] = '{32'h0, 0, 10, 0, 0, 0, 1, 0};
    rows[5] = '{32'h1 << 31, 0, 31, 1, 1, 31, 0, 0};
    rows[6] = '{32'h1, 0, -1, 1, 1, 0, 0, 0};

    rst_n = 1'b0; start = 1'b0; valid = 1'b0; addr = '0; data = 1'b0; data_b = 1'b0;
    repeat (2) @(negedge clk);
    all_zero("reset");
    rst_n = 1'b1;

    // Samples in IDLE must be ignored.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      valid = 1'b1; addr = 5'(i + 7); data = ~addr[0];
    end
    @(negedge clk);
    valid = 1'b0;
    all_zero("idle valid");

    foreach (rows[r]) begin
      string tag;
      tag = $sformatf("row%0d", r);
      run_pass(tag, rows[r].mask, rows[r].dup, rows[r].start_at);
      chk({tag, " done"}, done, 1);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " pass"}, pass, rows[r].e_pass);
      chk({tag, " count"}, cnt, rows[r].e_cnt);
      chk({tag, " seq"}, seq, rows[r].e_seq);
      chk({tag, " fv"}, fv, rows[r].e_fv);
      if (rows[r].e_fv) chk({tag, " fa"}, fa, rows[r].e_fa);
      chk({tag, " sat done"}, done_b, 1);
      chk({tag, " sat count"}, cnt_b, 3);
      chk({tag, " sat pass"}, pass_b, 0);
      chk({tag, " sat fa"}, fa_b, 0);
      @(negedge clk);
      chk({tag, " done held"}, done, 1);
    end

    // Reset in the middle of a faulty pass.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      valid = 1'b1; addr = 5'(i); data = addr[0] ^ (i == 3);
      @(negedge clk);
    end
    chk("mid busy", busy, 1);
    chk("mid count", cnt, 1);
    chk("mid fa", fa, 3);
    rst_n = 1'b0;
    #1;
    all_zero("async reset");
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    all_zero("after reset");

    run_pass("post reset", 32'h0, 0, -1);
    chk("post reset done", done, 1);
    chk("post reset pass", pass, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
